// File: rtl/saddsub_pipe.sv
// Pipelined signed add/subtract with optional saturation, valid/ready
// handshake on both ends and a saturating overflow counter.
module saddsub_pipe #(
   parameter int DATAWIDTH = 64,
   parameter int STAGES    = 2,
   parameter int SATURATE  = 1,
   parameter int CNTWIDTH  = 16
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic                 op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] result,
   output logic                 ovf,
   output logic [CNTWIDTH-1:0]  ovf_cnt,
   input  logic                 cnt_clr
);

   localparam int W = DATAWIDTH;

   logic              adv;
   logic              xfer;
   logic [W:0]        ax;
   logic [W:0]        bx;
   logic [W:0]        sum;
   logic              raw_ovf;
   logic [W-1:0]      res_in;
   logic [STAGES-1:0] vld;
   logic [W-1:0]      dat [STAGES];
   logic              ovr [STAGES];
   logic [CNTWIDTH-1:0] cnt;

   // Global stall: the whole pipe moves only when the tail can drain.
   assign adv      = !vld[STAGES-1] || out_ready;
   assign in_ready = adv;
   assign xfer     = vld[STAGES-1] && out_ready;

   always_comb begin
      ax      = {a[W-1], a};
      bx      = {b[W-1], b};
      sum     = op ? (ax + bx) : (ax - bx);
      raw_ovf = sum[W] ^ sum[W-1];
      res_in  = sum[W-1:0];
      // sum[W] holds the true sign of the unbounded result
      if ((SATURATE != 0) && raw_ovf) begin
         res_in = sum[W] ? {1'b1, {(W-1){1'b0}}}
                         : {1'b0, {(W-1){1'b1}}};
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         vld <= '0;
         for (int i = 0; i < STAGES; i++) begin
            dat[i] <= '0;
            ovr[i] <= 1'b0;
         end
      end else if (adv) begin
         vld[0] <= in_valid;
         dat[0] <= res_in;
         ovr[0] <= raw_ovf;
         for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
            ovr[i] <= ovr[i-1];
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else if (xfer && ovr[STAGES-1] && (cnt != '1)) begin
         cnt <= cnt + CNTWIDTH'(1);
      end
   end

   assign out_valid = vld[STAGES-1];
   assign result    = dat[STAGES-1];
   assign ovf       = ovr[STAGES-1];
   assign ovf_cnt   = cnt;

endmodule

// File: tb/tb_saddsub_pipe.sv
// Scoreboard bench: three saddsub_pipe configurations share one stimulus
// stream; a negedge monitor checks every cycle against an age-tracked model.
module tb_saddsub_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       op;
   logic       out_ready;
   logic       cnt_clr;

   logic        rdy0, rdy1, rdy2;
   logic        ov0, ov1, ov2;
   logic [7:0]  r0, r1, r2;
   logic        f0, f1, f2;
   logic [15:0] c0, c1;
   logic [1:0]  c2;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       op;
      int         age;
   } ent_t;

   ent_t q[$];
   int   m16 = 0;
   int   m2  = 0;

   always #5 clk = ~clk;

   saddsub_pipe #(.DATAWIDTH(8), .STAGES(2), .SATURATE(1), .CNTWIDTH(16)) u0 (
      .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(rdy0),
      .a(a), .b(b), .op(op), .out_valid(ov0), .out_ready(out_ready),
      .result(r0), .ovf(f0), .ovf_cnt(c0), .cnt_clr(cnt_clr)
   );

   saddsub_pipe #(.DATAWIDTH(8), .STAGES(2), .SATURATE(0), .CNTWIDTH(16)) u1 (
      .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(rdy1),
      .a(a), .b(b), .op(op), .out_valid(ov1), .out_ready(out_ready),
      .result(r1), .ovf(f1), .ovf_cnt(c1), .cnt_clr(cnt_clr)
   );

   saddsub_pipe #(.DATAWIDTH(8), .STAGES(2), .SATURATE(1), .CNTWIDTH(2)) u2 (
      .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(rdy2),
      .a(a), .b(b), .op(op), .out_valid(ov2), .out_ready(out_ready),
      .result(r2), .ovf(f2), .ovf_cnt(c2), .cnt_clr(cnt_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic void model(input logic [7:0] x, input logic [7:0] y,
                                 input logic o, input bit sat,
                                 output logic [7:0] r, output logic v);
      int sx, sy, t;
      sx = int'($signed(x));
      sy = int'($signed(y));
      t  = o ? sx + sy : sx - sy;
      v  = (t > 127) || (t < -128);
      if (sat && v) r = (t > 0) ? 8'h7F : 8'h80;
      else          r = 8'(t);
   endfunction

   always @(negedge clk) begin
      logic       ev, xf, advm;
      logic [7:0] er_s, er_w;
      logic       eo;
      if (!rst) begin
         q.delete();
         m16 = 0;
         m2  = 0;
         chk("rst_out_valid", {29'd0, ov0, ov1, ov2}, 32'd0);
         chk("rst_result", {8'd0, r0, r1, r2}, 32'd0);
         chk("rst_ovf", {29'd0, f0, f1, f2}, 32'd0);
         chk("rst_cnt", {14'd0, c2, c0}, 32'd0);
         chk("rst_in_ready", {29'd0, rdy0, rdy1, rdy2}, 32'd7);
      end else begin
         ev = (q.size() > 0) && (q[0].age >= 1);
         eo = 1'b0;
         chk("out_valid", {29'd0, ov0, ov1, ov2}, {29'd0, ev, ev, ev});
         advm = !ev || out_ready;
         chk("in_ready", {29'd0, rdy0, rdy1, rdy2},
             {29'd0, advm, advm, advm});
         if (ev) begin
            model(q[0].a, q[0].b, q[0].op, 1'b1, er_s, eo);
            model(q[0].a, q[0].b, q[0].op, 1'b0, er_w, eo);
            chk("result_sat", {24'd0, r0}, {24'd0, er_s});
            chk("result_wrap", {24'd0, r1}, {24'd0, er_w});
            chk("result_cnt2", {24'd0, r2}, {24'd0, er_s});
            chk("ovf", {29'd0, f0, f1, f2}, {29'd0, eo, eo, eo});
         end
         chk("ovf_cnt16", {16'd0, c0}, m16);
         chk("ovf_cnt16_wrap", {16'd0, c1}, m16);
         chk("ovf_cnt2", {30'd0, c2}, m2);
         xf = ev && out_ready;
         if (cnt_clr) begin
            m16 = 0;
            m2  = 0;
         end else if (xf && eo) begin
            if (m16 < 65535) m16++;
            if (m2 < 3) m2++;
         end
         if (advm) begin
            if (xf) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (in_valid) q.push_back('{a: a, b: b, op: op, age: 0});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y,
                       input logic o);
      in_valid = 1'b1;
      a  = x;
      b  = y;
      op = o;
      step();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      repeat (3) step();
      chk("in_ready_in_reset", {31'd0, rdy0}, 32'd1);
      rst = 1'b1;

      // 100 - (-50) saturates to 127, visible one edge after acceptance
      send(8'd100, 8'hCE, 1'b0);
      chk("lat_not_yet", {31'd0, ov0}, 32'd0);
      idle(1);
      chk("lat_valid", {31'd0, ov0}, 32'd1);
      chk("sat_pos", {24'd0, r0}, 32'h7F);
      chk("sat_ovf", {31'd0, f0}, 32'd1);
      idle(1);
      chk("cnt_after_xfer", {16'd0, c0}, 32'd1);

      // wrap corner cases
      send(8'h80, 8'd1, 1'b0);
      send(8'h80, 8'hFF, 1'b1);
      idle(1);
      chk("wrap_sub", {24'd0, r1}, 32'h7F);
      chk("sat_neg", {24'd0, r0}, 32'h80);
      idle(2);

      // back-to-back stream
      for (int i = 0; i < 10; i++) begin
         send(8'($urandom), 8'($urandom), 1'($urandom));
         chk("stream_in_ready", {31'd0, rdy0}, 32'd1);
      end
      idle(3);

      // stall with a full pipe
      out_ready = 1'b0;
      send(8'd10, 8'd20, 1'b1);
      send(8'd30, 8'hFB, 1'b0);
      a = 8'd7;
      b = 8'd9;
      op = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_in_ready", {31'd0, rdy0}, 32'd0);
         chk("stall_hold", {24'd0, r0}, 32'd30);
      end
      out_ready = 1'b1;
      step();
      idle(4);

      // counter saturation and clear priority
      cnt_clr = 1'b1;
      idle(1);
      cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) send(8'd100, 8'd100, 1'b1);
      idle(3);
      chk("cnt2_sticks", {30'd0, c2}, 32'd3);
      chk("cnt16_five", {16'd0, c0}, 32'd5);
      send(8'd100, 8'd100, 1'b1);
      cnt_clr = 1'b1;
      idle(1);
      cnt_clr = 1'b0;
      chk("clr_wins16", {16'd0, c0}, 32'd0);
      chk("clr_wins2", {30'd0, c2}, 32'd0);

      // reset with items in flight
      send(8'd120, 8'd100, 1'b1);
      send(8'd3, 8'd4, 1'b1);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, ov0}, 32'd0);
      chk("mid_rst_cnt", {16'd0, c0}, 32'd0);
      step();
      step();
      rst = 1'b1;
      idle(4);
      send(8'd5, 8'd6, 1'b0);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
